// File: rtl/mem_pkg.sv
// Shared types and address helpers for the data-memory responder.
// The state encoding and address decode live here so the top and any future bench agree on them.
package mem_pkg;

   typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

   localparam int WORD_BYTES = 4;

   function automatic logic [29:0] word_index(input logic [31:0] addr);
      return addr[31:2];
   endfunction

   // Misaligned, or outside the 2**aw-word array.
   function automatic logic addr_err(input logic [31:0] addr, input int aw);
      logic [31:0] hi;
      hi = addr >> (aw + 2);
      return (addr[1:0] != 2'b00) || (hi != 32'd0);
   endfunction

endpackage

// File: rtl/mem_array.sv
// Word-addressed SRAM with per-byte write enables and a registered read port.
// Contents are never reset.
module mem_array
   import mem_pkg::*;
#(
   parameter int ADDR_WIDTH = 10
) (
   input  logic                  clk,
   input  logic                  en,
   input  logic                  we,
   input  logic [ADDR_WIDTH-1:0] idx,
   input  logic [31:0]           wdata,
   input  logic [WORD_BYTES-1:0] be,
   output logic [31:0]           rdata
);

   logic [31:0] mem [2**ADDR_WIDTH];

   // rdata only moves on a read access, so it holds the last load result
   always_ff @(posedge clk) begin
      if (en) begin
         if (we) begin
            for (int i = 0; i < WORD_BYTES; i++)
               if (be[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
         end else begin
            rdata <= mem[idx];
         end
      end
   end

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder: one request at a time, fixed access latency, single response
// carrying load data or a store ack plus an error flag.
module data_mem_responder
   import mem_pkg::*;
#(
   parameter int ADDR_WIDTH = 10,
   parameter int LATENCY    = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [3:0]  req_be,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [31:0] resp_rdata,
   output logic        resp_err
);

   state_t      state, state_n;
   logic [3:0]  cnt, cnt_n;
   logic        wr_q;
   logic [31:0] addr_q, wdata_q;
   logic [3:0]  be_q;
   logic        mem_en, bad;
   logic [31:0] arr_rdata;
   logic [ADDR_WIDTH-1:0] idx;

   assign bad = addr_err(addr_q, ADDR_WIDTH);
   assign idx = ADDR_WIDTH'(word_index(addr_q));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         be_q    <= '0;
      end else if (state == IDLE && req_valid) begin
         wr_q    <= req_write;
         addr_q  <= req_addr;
         wdata_q <= req_wdata;
         be_q    <= req_be;
      end
   end

   always_comb begin
      state_n    = state;
      cnt_n      = cnt;
      mem_en     = 1'b0;
      req_ready  = 1'b0;
      resp_valid = 1'b0;
      case (state)
         IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               state_n = BUSY;
               cnt_n   = 4'(LATENCY - 1);
            end
         end
         BUSY: begin
            if (cnt == 4'd0) begin
               // bad requests still take the full latency but never touch the array
               mem_en  = ~bad;
               state_n = RESP;
            end else begin
               cnt_n = cnt - 4'd1;
            end
         end
         RESP: begin
            resp_valid = 1'b1;
            if (resp_ready) state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   // Gating by resp_valid makes both outputs drop to zero the instant reset asserts.
   assign resp_err   = resp_valid & bad;
   assign resp_rdata = (resp_valid && !bad && !wr_q) ? arr_rdata : 32'd0;

   mem_array #(.ADDR_WIDTH(ADDR_WIDTH)) u_array (
      .clk   (clk),
      .en    (mem_en),
      .we    (wr_q),
      .idx   (idx),
      .wdata (wdata_q),
      .be    (be_q),
      .rdata (arr_rdata)
   );

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: directed requests push expectations,
// a negedge monitor pops and compares on every response handshake.
module tb_data_mem_responder;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        req_valid = 1'b0, req_write = 1'b0, resp_ready = 1'b1;
   logic [31:0] req_addr = '0, req_wdata = '0;
   logic [3:0]  req_be = '0;

   logic        req_ready, resp_valid, resp_err;
   logic [31:0] resp_rdata;
   logic        rr1, rv1, re1, rr15, rv15, re15;
   logic [31:0] rd1, rd15;

   always #5 clk = ~clk;

   data_mem_responder #(.ADDR_WIDTH(10), .LATENCY(2)) dut (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
      .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
      .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata), .resp_err(resp_err));

   data_mem_responder #(.ADDR_WIDTH(10), .LATENCY(1)) dut_l1 (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(rr1),
      .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
      .resp_valid(rv1), .resp_ready(resp_ready), .resp_rdata(rd1), .resp_err(re1));

   data_mem_responder #(.ADDR_WIDTH(10), .LATENCY(15)) dut_l15 (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(rr15),
      .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
      .resp_valid(rv15), .resp_ready(resp_ready), .resp_rdata(rd15), .resp_err(re15));

   typedef struct {logic [31:0] rdata; logic err;} exp_t;
   exp_t q[$];
   int checks = 0, failures = 0, cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (!reset && resp_valid && resp_ready) begin
         if (q.size() == 0) begin
            checks++; failures++;
            $display("FAIL unexpected_resp actual=%h/%b expected=none", resp_rdata, resp_err);
         end else begin
            e = q.pop_front();
            chk("resp_rdata", resp_rdata, e.rdata);
            chk("resp_err", 32'(resp_err), 32'(e.err));
         end
      end
   end

   task automatic do_req(input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] be, input logic push, input logic [31:0] er,
                         input logic ee, output int acc);
      int t;
      exp_t e;
      e.rdata = er; e.err = ee;
      if (push) q.push_back(e);
      @(posedge clk); #1;
      req_write = w; req_addr = a; req_wdata = d; req_be = be; req_valid = 1'b1;
      t = 0;
      @(negedge clk);
      while (!req_ready && t < 100) begin @(negedge clk); t++; end
      if (t >= 100) begin
         checks++; failures++;
         $display("FAIL accept_timeout actual=not_ready expected=ready");
      end
      @(posedge clk); #1;
      acc = cyc;
      req_valid = 1'b0;
   endtask

   task automatic wait_lat(output int n);
      n = 0;
      @(negedge clk);
      while (!resp_valid && n < 40) begin @(posedge clk); n++; @(negedge clk); end
   endtask

   task automatic drain();
      int t;
      t = 0;
      while (q.size() != 0 && t < 200) begin @(negedge clk); t++; end
      if (q.size() != 0) begin
         checks++; failures++;
         $display("FAIL drain_timeout actual=%0d expected=0", q.size());
         q.delete();
      end
      @(posedge clk); #1;
   endtask

   task automatic chk_reset_outs(input string tag);
      chk({tag, "_req_ready"}, 32'(req_ready), 32'd1);
      chk({tag, "_resp_valid"}, 32'(resp_valid), 32'd0);
      chk({tag, "_resp_err"}, 32'(resp_err), 32'd0);
      chk({tag, "_resp_rdata"}, resp_rdata, 32'd0);
   endtask

   initial begin
      int n, a0, a1, a2, f1, f2, f15;
      #12 chk_reset_outs("por");
      @(posedge clk); #1 reset = 1'b0;

      // full store, then latency and readback
      do_req(1, 32'h10, 32'hDEADBEEF, 4'hF, 1, 32'h0, 0, a0);
      wait_lat(n);
      chk("lat2", 32'(n), 32'd2);
      drain();
      do_req(0, 32'h10, 32'h0, 4'h0, 1, 32'hDEADBEEF, 0, a0); drain();

      // partial store
      do_req(1, 32'h10, 32'h000000AA, 4'h1, 1, 32'h0, 0, a0); drain();
      do_req(0, 32'h10, 32'h0, 4'hF, 1, 32'hDEADBEAA, 0, a0); drain();

      // errors: misaligned load, out-of-range store that would alias word 0
      do_req(0, 32'h12, 32'h0, 4'hF, 1, 32'h0, 1, a0); drain();
      do_req(1, 32'h0, 32'h0BADF00D, 4'hF, 1, 32'h0, 0, a0); drain();
      do_req(1, 32'h1000, 32'h55555555, 4'hF, 1, 32'h0, 1, a0); drain();
      do_req(0, 32'h0, 32'h0, 4'h0, 1, 32'h0BADF00D, 0, a0); drain();

      // be=0 store is a no-op with a normal ack
      do_req(1, 32'h0, 32'hFFFFFFFF, 4'h0, 1, 32'h0, 0, a0); drain();
      do_req(0, 32'h0, 32'h0, 4'h0, 1, 32'h0BADF00D, 0, a0); drain();

      // backpressure with a competing request held
      resp_ready = 1'b0;
      do_req(0, 32'h10, 32'h0, 4'hF, 1, 32'hDEADBEAA, 0, a0);
      wait_lat(n);
      chk("bp_lat", 32'(n), 32'd2);
      req_valid = 1'b1; req_addr = 32'h12; req_write = 1'b0;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk("bp_valid", 32'(resp_valid), 32'd1);
         chk("bp_rdata", resp_rdata, 32'hDEADBEAA);
         chk("bp_req_ready", 32'(req_ready), 32'd0);
      end
      @(posedge clk); #1;
      resp_ready = 1'b1; req_valid = 1'b0;
      @(posedge clk); #1;
      chk("bp_idle_ready", 32'(req_ready), 32'd1);
      chk("bp_idle_valid", 32'(resp_valid), 32'd0);
      drain();

      // reset during BUSY aborts the store
      do_req(1, 32'h20, 32'h0, 4'hF, 1, 32'h0, 0, a0); drain();
      do_req(1, 32'h20, 32'h12345678, 4'hF, 0, 32'h0, 0, a0);
      @(posedge clk); @(negedge clk);
      reset = 1'b1;
      #1 chk_reset_outs("midrst");
      @(posedge clk); @(posedge clk); #1 reset = 1'b0;
      do_req(0, 32'h20, 32'h0, 4'hF, 1, 32'h0, 0, a0); drain();

      // back-to-back with resp_ready high: LATENCY+2 spacing
      do_req(1, 32'h30, 32'h00000011, 4'hF, 1, 32'h0, 0, a0);
      do_req(0, 32'h30, 32'h0, 4'hF, 1, 32'h00000011, 0, a1);
      do_req(0, 32'h10, 32'h0, 4'hF, 1, 32'hDEADBEAA, 0, a2);
      chk("b2b_gap1", 32'(a1 - a0), 32'd4);
      chk("b2b_gap2", 32'(a2 - a1), 32'd4);
      drain();

      // latency boundaries: all three instances accept the same request
      reset = 1'b1;
      @(posedge clk); #1 reset = 1'b0;
      resp_ready = 1'b0;
      begin
         exp_t e;
         e.rdata = 32'hDEADBEAA; e.err = 1'b0;
         q.push_back(e);
      end
      req_write = 1'b0; req_addr = 32'h10; req_be = 4'hF; req_valid = 1'b1;
      @(posedge clk); #1 req_valid = 1'b0;
      f1 = 0; f2 = 0; f15 = 0;
      for (int i = 1; i <= 20; i++) begin
         @(posedge clk); #1;
         if (rv1 && f1 == 0) f1 = i;
         if (resp_valid && f2 == 0) f2 = i;
         if (rv15 && f15 == 0) f15 = i;
      end
      chk("lat1", 32'(f1), 32'd1);
      chk("lat2_b", 32'(f2), 32'd2);
      chk("lat15", 32'(f15), 32'd15);
      resp_ready = 1'b1;
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
Memory-side responder for the core's data-memory port. It accepts one load/store request at a time over a valid/ready handshake and models a fixed access latency. It returns a single response per request: read data or write acknowledge, plus an error flag. It sits between the processor's load/store path and a word-addressed SRAM array. It is the target for the future multi-cycle/stalling datapath.

Parameters:
ADDR_WIDTH, 10, word-address bits; array holds 2**ADDR_WIDTH 32-bit words
LATENCY, 2, cycles from request acceptance to response valid; legal range 1..15

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
req_valid  input  1  request present
req_ready  output  1  responder can accept a request
req_write  input  1  1 = store, 0 = load
req_addr  input  32  byte address
req_wdata  input  32  store data
req_be  input  4  byte enables; bit i enables byte lane i (bits 8i+7:8i)
resp_valid  output  1  response present
resp_ready  input  1  requester consumes response
resp_rdata  output  32  load data; 0 for stores and errors
resp_err  output  1  request was misaligned or out of range

Behaviour:
- One clock; reset is asynchronous and active-high, named reset; clock named clk.
- Reset values: state=IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, latency counter=0.
- Reset does not clear array contents. Contents are undefined at power-up.
- States: IDLE, BUSY, RESP.
- IDLE:
  - req_ready=1.
  - On an edge with req_valid=1: capture write, addr, wdata and be; load counter with LATENCY-1; go to BUSY.
- BUSY:
  - req_ready=0.
  - Decrement the counter each edge.
  - At the edge where counter==0, perform the access, register the result, and go to RESP.
  - Net latency: resp_valid rises exactly LATENCY cycles after the accepting edge.
- RESP:
  - resp_valid=1; resp_rdata and resp_err are held stable until consumed.
  - On an edge with resp_ready=1, go to IDLE.
  - req_ready stays 0 in RESP. There is no overlap of a new request with an outstanding response, so throughput is one request per LATENCY+2 cycles.
- Error cases, detected on the captured request:
  - Misaligned: addr[1:0]!=0.
  - Out of range: addr[31:ADDR_WIDTH+2]!=0.
  - On error: resp_err=1, resp_rdata=0, no array write, timing unchanged.
- Store: writes only the enabled byte lanes of word addr[ADDR_WIDTH+1:2]. be=0000 is legal and acts as a no-op write with a normal ack. resp_rdata=0.
- Load: returns the full 32-bit word; be is ignored.
- Ordering: a store completes before its response. A load accepted after a store's response sees the stored data.
- req_* inputs are sampled only on the accepting edge. Changes while BUSY or RESP are ignored.
- resp_ready asserted while resp_valid=0 is ignored.
- Reset mid-operation (BUSY or RESP) aborts the transaction.
  - If reset is asserted before the completion edge, the pending store is not written.
  - The response is dropped; outputs return to reset values immediately (asynchronously).

Decomposition:
- Shared package mem_pkg:
  - state enum {IDLE, BUSY, RESP}
  - WORD_BYTES=4
  - function word_index(addr)
  - function addr_err(addr, ADDR_WIDTH)
- One sub-module, mem_array:
  - Parameter ADDR_WIDTH.
  - Synchronous byte-enable write; synchronous read on the same enable.
  - No reset.
  - Instantiated once inside data_mem_responder.

Test Plan:
- Reset with LATENCY=2 -> req_ready=1, resp_valid=0, resp_err=0. Store addr=0x10, wdata=0xDEADBEEF, be=1111 -> resp_valid rises 2 cycles after acceptance, resp_err=0, resp_rdata=0. Then load 0x10 -> resp_rdata=0xDEADBEEF.
- Partial store: store addr=0x10, wdata=0x000000AA, be=0001 over 0xDEADBEEF -> a following load returns 0xDEADBEAA.
- Error cases:
  - Load addr=0x12 -> resp_err=1, resp_rdata=0.
  - Store addr=0x1000 with ADDR_WIDTH=10 -> resp_err=1, and a later load of 0x0 is unchanged.
- Backpressure: hold resp_ready=0 for 5 cycles after resp_valid -> resp_valid and data stay stable, req_ready=0, and a new req_valid is not accepted. Release resp_ready -> IDLE next cycle.
- Assert reset two cycles into BUSY for a store to 0x20 with 0x12345678 over prior 0x0 -> outputs go to reset values at once. A later load of 0x20 returns 0x0.
- Boundaries:
  - LATENCY=1 -> response the cycle after acceptance.
  - LATENCY=15 -> response after 15 cycles.
  - Back-to-back requests with resp_ready tied high -> one accepted every LATENCY+2 cycles.
